// File: rtl/execute_unit_pipe_if.sv
// execute_unit_pipe_if: operation/result handshake bundle between the issue stage and execute_unit_pipe.
`default_nettype none
interface execute_unit_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic [WIDTH-1:0] sign_ext_imm;
  logic [SHW-1:0]   shamt;
  logic [1:0]       op_b_sel;
  logic [3:0]       alu_fun;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [TAG_W-1:0] tag_out;
  logic             busy;

  modport master (
    output in_valid, data_a, data_b, sign_ext_imm, shamt, op_b_sel, alu_fun, tag_in, out_ready,
    input  in_ready, out_valid, result, zero, tag_out, busy
  );

  modport slave (
    input  in_valid, data_a, data_b, sign_ext_imm, shamt, op_b_sel, alu_fun, tag_in, out_ready,
    output in_ready, out_valid, result, zero, tag_out, busy
  );
endinterface
`default_nettype wire

// File: rtl/execute_unit_pipe.sv
// execute_unit_pipe: registered execute stage with valid/ready output; EXEC_MULDIV_EN adds the
// iterative MUL/DIVU/REMU path (one bit per cycle). Rev 1.0
`default_nettype none
module execute_unit_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  execute_unit_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SUB  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_LUI  = 4'd11;

  logic [WIDTH-1:0] b_op;
  logic [SHW-1:0]   sh_amt;
  logic [WIDTH-1:0] alu_res;
  logic             in_ready;
  logic             accept;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic [TAG_W-1:0] tag_q;

  always_comb begin
    b_op = bus.data_b;
    case (bus.op_b_sel)
      2'd0:    b_op = bus.data_b;
      2'd1:    b_op = bus.sign_ext_imm;
      2'd2:    b_op = {{(WIDTH-SHW){1'b0}}, bus.shamt};
      default: b_op = {{(WIDTH-SHW){1'b0}}, bus.data_b[SHW-1:0]};
    endcase
  end

  assign sh_amt = b_op[SHW-1:0];

  // Codes 12-15 fall to the default: reserved, or handled by the iterative path.
  always_comb begin
    alu_res = '0;
    case (bus.alu_fun)
      OP_AND:  alu_res = bus.data_a & b_op;
      OP_OR:   alu_res = bus.data_a | b_op;
      OP_ADD:  alu_res = bus.data_a + b_op;
      OP_XOR:  alu_res = bus.data_a ^ b_op;
      OP_NOR:  alu_res = ~(bus.data_a | b_op);
      OP_SLL:  alu_res = bus.data_a << sh_amt;
      OP_SRL:  alu_res = bus.data_a >> sh_amt;
      OP_SRA:  alu_res = $unsigned($signed(bus.data_a) >>> sh_amt);
      OP_SUB:  alu_res = bus.data_a - b_op;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.data_a) < $signed(b_op))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.data_a < b_op)};
      OP_LUI:  alu_res = b_op << (WIDTH/2);
      default: alu_res = '0;
    endcase
  end

  assign accept = bus.in_valid && in_ready;

`ifdef EXEC_MULDIV_EN
  localparam logic [0:0]   S_IDLE   = 1'b0;
  localparam logic [0:0]   S_MD_RUN = 1'b1;
  localparam logic [1:0]   MD_MUL   = 2'd0;
  localparam logic [1:0]   MD_DIVU  = 2'd1;
  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  logic [0:0]       state_q, state_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [1:0]       mdop_q, mdop_d;
  logic [TAG_W-1:0] mdtag_q, mdtag_d;
  logic [WIDTH:0]   rem_sh;
  logic             is_md;
  logic             md_done;
  logic [WIDTH-1:0] md_res;

  assign is_md = (bus.alu_fun == 4'd12) || (bus.alu_fun == 4'd13) || (bus.alu_fun == 4'd14);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept && is_md) state_d = S_MD_RUN;
      S_MD_RUN: if (cnt_q == CNT_ONE) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
    bus.busy = (state_q == S_MD_RUN);
  end

  // acc holds the product or partial remainder; opa is the multiplicand or the
  // dividend being shifted out while quotient bits shift in from the right.
  always_comb begin
    acc_d   = acc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    mdop_d  = mdop_q;
    mdtag_d = mdtag_q;
    rem_sh  = {acc_q, opa_q[WIDTH-1]};
    if (state_q == S_IDLE) begin
      if (accept && is_md) begin
        acc_d   = '0;
        opa_d   = bus.data_a;
        opb_d   = b_op;
        cnt_d   = CNT_INIT;
        mdop_d  = bus.alu_fun[1:0];
        mdtag_d = bus.tag_in;
      end
    end else begin
      cnt_d = cnt_q - CNT_ONE;
      if (mdop_q == MD_MUL) begin
        if (opb_q[0]) acc_d = acc_q + opa_q;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
      end else if (rem_sh >= {1'b0, opb_q}) begin
        acc_d = WIDTH'(rem_sh - {1'b0, opb_q});
        opa_d = {opa_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = rem_sh[WIDTH-1:0];
        opa_d = {opa_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      mdop_q  <= '0;
      mdtag_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      mdop_q  <= mdop_d;
      mdtag_q <= mdtag_d;
    end
  end

  assign md_done = (state_q == S_MD_RUN) && (cnt_q == CNT_ONE);
  assign md_res  = (mdop_q == MD_DIVU) ? opa_d : acc_d;

  // Completion never collides with a held result: accept required the output to drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      tag_q       <= '0;
    end else if (accept && !is_md) begin
      out_valid_q <= 1'b1;
      result_q    <= alu_res;
      zero_q      <= (alu_res == '0);
      tag_q       <= bus.tag_in;
    end else if (md_done) begin
      out_valid_q <= 1'b1;
      result_q    <= md_res;
      zero_q      <= (md_res == '0);
      tag_q       <= mdtag_q;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
`else
  always_comb begin
    in_ready = !out_valid_q || bus.out_ready;
    bus.busy = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      tag_q       <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      result_q    <= alu_res;
      zero_q      <= (alu_res == '0);
      tag_q       <= bus.tag_in;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.tag_out   = tag_q;
endmodule
`default_nettype wire

// File: tb/tb_execute_unit_pipe.sv
// tb_execute_unit_pipe: directed self-checking bench for execute_unit_pipe (WIDTH=32, TAG_W=5).
`default_nettype none
module tb_execute_unit_pipe;
  localparam int WIDTH = 32;
  localparam int TAG_W = 5;

  typedef struct packed {
    logic [3:0]  fun;
    logic [1:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;

  execute_unit_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  execute_unit_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [3:0] fun, input logic [1:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm, input logic [4:0] sh,
                          input logic [TAG_W-1:0] tag);
    bus.in_valid     = 1'b1;
    bus.alu_fun      = fun;
    bus.op_b_sel     = sel;
    bus.data_a       = a;
    bus.data_b       = b;
    bus.sign_ext_imm = imm;
    bus.shamt        = sh;
    bus.tag_in       = tag;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", bus.result); end
    n_checks++; if (bus.zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b expected 1", bus.zero); end
    n_checks++; if (bus.tag_out !== 5'd0) begin n_fail++; $display("FAIL reset_tag: got %0d expected 0", bus.tag_out); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    reset = 1'b0;
  endtask

  task automatic test_add_overflow();
    drive_op(4'd2, 2'd1, 32'h7FFFFFFF, 32'h0, 32'h00000001, 5'd0, 5'd3);
    step();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL add_ovf_valid: got %b expected 1", bus.out_valid); end
    n_checks++; if (bus.result !== 32'h80000000) begin n_fail++; $display("FAIL add_ovf_result: got %h expected 80000000", bus.result); end
    n_checks++; if (bus.zero !== 1'b0) begin n_fail++; $display("FAIL add_ovf_zero: got %b expected 0", bus.zero); end
    n_checks++; if (bus.tag_out !== 5'd3) begin n_fail++; $display("FAIL add_ovf_tag: got %0d expected 3", bus.tag_out); end
    step();
  endtask

  task automatic test_sra_sub();
    drive_op(4'd7, 2'd2, 32'h80000000, 32'h0, 32'h0, 5'd4, 5'd4);
    step();
    n_checks++; if (bus.result !== 32'hF8000000) begin n_fail++; $display("FAIL sra_result: got %h expected f8000000", bus.result); end
    n_checks++; if (bus.zero !== 1'b0) begin n_fail++; $display("FAIL sra_zero: got %b expected 0", bus.zero); end
    drive_op(4'd8, 2'd0, 32'd5, 32'd5, 32'h0, 5'd0, 5'd5);
    step();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL sub_result: got %h expected 00000000", bus.result); end
    n_checks++; if (bus.zero !== 1'b1) begin n_fail++; $display("FAIL sub_zero: got %b expected 1", bus.zero); end
    n_checks++; if (bus.tag_out !== 5'd5) begin n_fail++; $display("FAIL sub_tag: got %0d expected 5", bus.tag_out); end
    step();
  endtask

  task automatic test_alu_vectors();
    vec_t v [12];
    v[0]  = '{4'd0,  2'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        5'd0,  32'hF000F000};
    v[1]  = '{4'd1,  2'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        5'd0,  32'hFFF0FFF0};
    v[2]  = '{4'd3,  2'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        5'd0,  32'h0FF00FF0};
    v[3]  = '{4'd4,  2'd0, 32'h0,        32'h0,        32'h0,        5'd0,  32'hFFFFFFFF};
    v[4]  = '{4'd5,  2'd3, 32'h00000001, 32'h00000024, 32'h0,        5'd0,  32'h00000010};
    v[5]  = '{4'd6,  2'd2, 32'h80000000, 32'h0,        32'h0,        5'd31, 32'h00000001};
    v[6]  = '{4'd7,  2'd1, 32'h80000000, 32'h0,        32'hFFFFFF21, 5'd0,  32'hC0000000};
    v[7]  = '{4'd8,  2'd0, 32'h0,        32'h1,        32'h0,        5'd0,  32'hFFFFFFFF};
    v[8]  = '{4'd9,  2'd0, 32'hFFFFFFFF, 32'h1,        32'h0,        5'd0,  32'h00000001};
    v[9]  = '{4'd10, 2'd0, 32'hFFFFFFFF, 32'h1,        32'h0,        5'd0,  32'h00000000};
    v[10] = '{4'd11, 2'd1, 32'hDEADBEEF, 32'h0,        32'h00001234, 5'd0,  32'h12340000};
    v[11] = '{4'd15, 2'd0, 32'h5,        32'h5,        32'h0,        5'd0,  32'h00000000};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive_op(v[i].fun, v[i].sel, v[i].a, v[i].b, v[i].imm, v[i].sh, 5'(i + 8));
      step();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== v[i].exp || bus.zero !== (v[i].exp == 32'h0) || bus.tag_out !== 5'(i + 8)) begin
        n_fail++;
        $display("FAIL alu_vec[%0d] fun=%0d: got valid=%b result=%h zero=%b tag=%0d expected valid=1 result=%h zero=%b tag=%0d",
                 i, v[i].fun, bus.out_valid, bus.result, bus.zero, bus.tag_out, v[i].exp, (v[i].exp == 32'h0), i + 8);
      end
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    drive_op(4'd2, 2'd0, 32'd1, 32'd2, 32'h0, 5'd0, 5'd1);
    step();
    drive_op(4'd2, 2'd0, 32'd10, 32'd20, 32'h0, 5'd0, 5'd2);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 32'd3 || bus.tag_out !== 5'd1) begin
        n_fail++;
        $display("FAIL b2b_hold[%0d]: got valid=%b in_ready=%b result=%h tag=%0d expected valid=1 in_ready=0 result=00000003 tag=1",
                 i, bus.out_valid, bus.in_ready, bus.result, bus.tag_out);
      end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_drain_ready: got %b expected 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd30 || bus.tag_out !== 5'd2) begin
      n_fail++;
      $display("FAIL b2b_second: got valid=%b result=%h tag=%0d expected valid=1 result=0000001e tag=2", bus.out_valid, bus.result, bus.tag_out);
    end
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_dup: got valid=%b expected 0", bus.out_valid); end
  endtask

`ifdef EXEC_MULDIV_EN
  task automatic test_muldiv();
    vec_t v [5];
    int cyc;
    int busy_cnt;
    bit rdy_seen;
    v[0] = '{4'd12, 2'd0, 32'h00010003, 32'h00020005, 32'h0, 5'd0, 32'h000B000F};
    v[1] = '{4'd13, 2'd0, 32'd100,      32'd7,        32'h0, 5'd0, 32'd14};
    v[2] = '{4'd14, 2'd0, 32'd100,      32'd7,        32'h0, 5'd0, 32'd2};
    v[3] = '{4'd13, 2'd0, 32'd5,        32'd0,        32'h0, 5'd0, 32'hFFFFFFFF};
    v[4] = '{4'd14, 2'd0, 32'd5,        32'd0,        32'h0, 5'd0, 32'd5};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_op(v[i].fun, v[i].sel, v[i].a, v[i].b, v[i].imm, v[i].sh, 5'(7 + i));
      step();
      bus.in_valid = 1'b0;
      cyc = 1;
      busy_cnt = 0;
      rdy_seen = 1'b0;
      while (bus.out_valid !== 1'b1 && cyc < 100) begin
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.in_ready !== 1'b0) rdy_seen = 1'b1;
        step();
        cyc++;
      end
      n_checks++;
      if (cyc != 33 || busy_cnt != 32 || rdy_seen) begin
        n_fail++;
        $display("FAIL md_timing[%0d]: got out_valid at cycle %0d busy_cycles=%0d in_ready_seen=%b expected cycle 33 busy_cycles=32 in_ready_seen=0",
                 i, cyc, busy_cnt, rdy_seen);
      end
      n_checks++;
      if (bus.result !== v[i].exp || bus.tag_out !== 5'(7 + i) || bus.busy !== 1'b0 || bus.zero !== 1'b0) begin
        n_fail++;
        $display("FAIL md_result[%0d] fun=%0d: got result=%h tag=%0d busy=%b zero=%b expected result=%h tag=%0d busy=0 zero=0",
                 i, v[i].fun, bus.result, bus.tag_out, bus.busy, bus.zero, v[i].exp, 7 + i);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_md();
    bus.out_ready = 1'b1;
    drive_op(4'd13, 2'd0, 32'd100, 32'd7, 32'h0, 5'd0, 5'd9);
    step();
    bus.in_valid = 1'b0;
    repeat (10) step();
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b expected 1", bus.busy); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: got valid=%b busy=%b in_ready=%b expected valid=0 busy=0 in_ready=1", bus.out_valid, bus.busy, bus.in_ready);
    end
    drive_op(4'd2, 2'd0, 32'd1, 32'd1, 32'h0, 5'd0, 5'd6);
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd2 || bus.tag_out !== 5'd6) begin
      n_fail++;
      $display("FAIL mid_add: got valid=%b result=%h tag=%0d expected valid=1 result=00000002 tag=6", bus.out_valid, bus.result, bus.tag_out);
    end
    repeat (40) step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_late_result: got valid=%b expected 0", bus.out_valid); end
  endtask
`else
  task automatic test_muldiv();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_op(4'(12 + i), 2'd0, 32'd100, 32'd7, 32'h0, 5'd0, 5'(20 + i));
      step();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== 32'h0 || bus.zero !== 1'b1 || bus.busy !== 1'b0 || bus.tag_out !== 5'(20 + i)) begin
        n_fail++;
        $display("FAIL md_disabled[%0d]: got valid=%b result=%h zero=%b busy=%b tag=%0d expected valid=1 result=00000000 zero=1 busy=0 tag=%0d",
                 i, bus.out_valid, bus.result, bus.zero, bus.busy, bus.tag_out, 20 + i);
      end
    end
    bus.in_valid = 1'b0;
    step();
  endtask
`endif

  task automatic test_reset_pending();
    bus.out_ready = 1'b0;
    drive_op(4'd2, 2'd0, 32'd3, 32'd4, 32'h0, 5'd0, 5'd11);
    step();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd7) begin n_fail++; $display("FAIL pend_before: got valid=%b result=%h expected valid=1 result=00000007", bus.out_valid, bus.result); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.zero !== 1'b1 || bus.tag_out !== 5'd0) begin
      n_fail++;
      $display("FAIL pend_reset: got valid=%b result=%h zero=%b tag=%0d expected valid=0 result=00000000 zero=1 tag=0", bus.out_valid, bus.result, bus.zero, bus.tag_out);
    end
    bus.out_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.data_a = '0;
    bus.data_b = '0;
    bus.sign_ext_imm = '0;
    bus.shamt = '0;
    bus.op_b_sel = '0;
    bus.alu_fun = '0;
    bus.tag_in = '0;
    test_reset();
    test_add_overflow();
    test_sra_sub();
    test_alu_vectors();
    test_back_to_back();
    test_muldiv();
`ifdef EXEC_MULDIV_EN
    test_reset_mid_md();
`endif
    test_reset_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
